// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-side signal bundle for the branch resolve unit.
// master = environment driving fetch/execute inputs, slave = the resolver.
interface branch_resolve_unit_if #(
  parameter int W_BTA = 32,
  parameter int W_CNT = 16
);
  logic             pushF;
  logic             hitF;
  logic [W_BTA-1:0] btaF;
  logic [W_BTA-1:0] pcF;
  logic             popE;
  logic             isBranchE;
  logic             branchTakenE;
  logic [W_BTA-1:0] aluBranchAddress;
  logic             redirectValid;
  logic [W_BTA-1:0] redirectPc;
  logic             flushF;
  logic             flushD;
  logic             btbUpdate;
  logic [W_BTA-1:0] btbPcPlus4;
  logic [W_BTA-1:0] btbTarget;
  logic [W_CNT-1:0] branchCount;
  logic [W_CNT-1:0] mispredictCount;
  logic             overflow;
  logic             underflow;

  modport master (
    output pushF, hitF, btaF, pcF, popE, isBranchE, branchTakenE, aluBranchAddress,
    input  redirectValid, redirectPc, flushF, flushD, btbUpdate, btbPcPlus4,
           btbTarget, branchCount, mispredictCount, overflow, underflow
  );

  modport slave (
    input  pushF, hitF, btaF, pcF, popE, isBranchE, branchTakenE, aluBranchAddress,
    output redirectValid, redirectPc, flushF, flushD, btbUpdate, btbPcPlus4,
           btbTarget, branchCount, mispredictCount, overflow, underflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Tracks fetch-stage BTB predictions in order and resolves them in execute,
// producing redirect, timed flush and BTB update.
module branch_resolve_unit #(
  parameter int DEPTH          = 4,
  parameter int W_BTA          = 32,
  parameter int RECOVER_CYCLES = 2,
  parameter int W_CNT          = 16
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic             hit;
    logic [W_BTA-1:0] bta;
    logic [W_BTA-1:0] pc;
  } entry_t;

  typedef enum logic {RUN, RECOVER} state_t;

  entry_t           mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  state_t           state, state_next;
  logic [3:0]       rcnt, rcnt_next;
  entry_t           head;
  logic             run, full, empty, pop_ok, push_ok, taken;
  logic             target_miss, false_taken, mispredict;
  logic [W_BTA-1:0] head_pc4, correct_pc;

  always_comb begin
    run         = (state == RUN);
    full        = (count == FULL_CNT);
    empty       = (count == '0);
    head        = mem[rd_ptr];
    pop_ok      = run && bus.popE && !empty;
    // a full queue still accepts a push when the oldest entry leaves this cycle
    push_ok     = run && bus.pushF && (!full || pop_ok);
    taken       = bus.isBranchE && bus.branchTakenE;
    head_pc4    = head.pc + W_BTA'(4);
    target_miss = pop_ok && taken && (!head.hit || (head.bta != bus.aluBranchAddress));
    false_taken = pop_ok && head.hit && !taken;
    mispredict  = target_miss || false_taken;
    correct_pc  = target_miss ? bus.aluBranchAddress : head_pc4;

    state_next = state;
    rcnt_next  = rcnt;
    case (state)
      RUN: begin
        if (mispredict) begin
          state_next = RECOVER;
          rcnt_next  = 4'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (rcnt == '0) state_next = RUN;
        else            rcnt_next  = rcnt - 4'd1;
      end
      default: state_next = RUN;
    endcase
  end

  assign bus.flushF = (state == RECOVER);
  assign bus.flushD = (state == RECOVER);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= RUN;
      rcnt                <= '0;
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      count               <= '0;
      bus.redirectValid   <= 1'b0;
      bus.redirectPc      <= '0;
      bus.btbUpdate       <= 1'b0;
      bus.btbPcPlus4      <= '0;
      bus.btbTarget       <= '0;
      bus.branchCount     <= '0;
      bus.mispredictCount <= '0;
      bus.overflow        <= 1'b0;
      bus.underflow       <= 1'b0;
    end else begin
      state             <= state_next;
      rcnt              <= rcnt_next;
      bus.redirectValid <= mispredict;
      bus.redirectPc    <= mispredict ? correct_pc : '0;
      bus.btbUpdate     <= target_miss;
      bus.btbPcPlus4    <= target_miss ? head_pc4 : '0;
      bus.btbTarget     <= target_miss ? bus.aluBranchAddress : '0;

      if (pop_ok && bus.isBranchE && (bus.branchCount != '1))
        bus.branchCount <= bus.branchCount + W_CNT'(1);
      if (mispredict && (bus.mispredictCount != '1))
        bus.mispredictCount <= bus.mispredictCount + W_CNT'(1);
      if (run && bus.pushF && full && !pop_ok) bus.overflow  <= 1'b1;
      if (run && bus.popE && empty)            bus.underflow <= 1'b1;

      // wrong-path entries are discarded for the whole recovery window
      if (!run) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        if (push_ok && !pop_ok)      count <= count + (PW+1)'(1);
        else if (pop_ok && !push_ok) count <= count - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= {bus.hitF, bus.btaF, bus.pcF};
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int RC    = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  branch_resolve_unit_if #(.W_BTA(32), .W_CNT(16)) bus ();
  branch_resolve_unit_if #(.W_BTA(32), .W_CNT(4))  bus_s ();

  branch_resolve_unit #(.DEPTH(DEPTH), .W_BTA(32), .RECOVER_CYCLES(RC), .W_CNT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  branch_resolve_unit #(.DEPTH(DEPTH), .W_BTA(32), .RECOVER_CYCLES(RC), .W_CNT(4)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] bta;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int          rec_left;
  logic        m_rv, m_upd, m_flush, m_of, m_uf;
  logic [31:0] m_rpc, m_p4, m_tgt;
  logic [15:0] m_bc, m_mc;

  // one clock of the reference model, using the inputs present at the edge
  task automatic model_step();
    ent_t e;
    logic tk, mis;
    if (!reset) begin
      mq.delete();
      rec_left = 0;
      {m_rv, m_upd, m_flush, m_of, m_uf} = '0;
      m_rpc = '0; m_p4 = '0; m_tgt = '0; m_bc = '0; m_mc = '0;
      return;
    end
    m_rv = 1'b0; m_upd = 1'b0; m_rpc = '0; m_p4 = '0; m_tgt = '0;
    if (rec_left > 0) begin
      rec_left--;
      mq.delete();
    end else begin
      mis = 1'b0;
      if (bus.popE) begin
        if (mq.size() == 0) m_uf = 1'b1;
        else begin
          e  = mq.pop_front();
          tk = bus.isBranchE && bus.branchTakenE;
          if (bus.isBranchE && m_bc != 16'hFFFF) m_bc++;
          if (tk && (!e.hit || e.bta != bus.aluBranchAddress)) begin
            mis = 1'b1; m_rpc = bus.aluBranchAddress;
            m_upd = 1'b1; m_p4 = e.pc + 32'd4; m_tgt = bus.aluBranchAddress;
          end else if (e.hit && !tk) begin
            mis = 1'b1; m_rpc = e.pc + 32'd4;
          end
          if (mis) begin
            m_rv = 1'b1;
            if (m_mc != 16'hFFFF) m_mc++;
          end
        end
      end
      if (bus.pushF) begin
        if (mq.size() < DEPTH) mq.push_back('{bus.hitF, bus.btaF, bus.pcF});
        else m_of = 1'b1;
      end
      if (mis) begin
        rec_left = RC;
        mq.delete();
      end
    end
    m_flush = (rec_left > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic p, input logic h, input logic [31:0] b, input logic [31:0] pc,
                       input logic o, input logic ib, input logic tk, input logic [31:0] alu);
    bus.pushF = p; bus.hitF = h; bus.btaF = b; bus.pcF = pc;
    bus.popE = o; bus.isBranchE = ib; bus.branchTakenE = tk; bus.aluBranchAddress = alu;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, 0, '0);
  endtask

  function automatic logic [133:0] dut_vec();
    return {bus.redirectValid, bus.redirectPc, bus.flushF, bus.flushD, bus.btbUpdate,
            bus.btbPcPlus4, bus.btbTarget, bus.branchCount, bus.mispredictCount,
            bus.overflow, bus.underflow};
  endfunction

  function automatic logic [133:0] exp_vec();
    return {m_rv, m_rpc, m_flush, m_flush, m_upd, m_p4, m_tgt, m_bc, m_mc, m_of, m_uf};
  endfunction

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (dut_vec() !== 134'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 134'd0);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
    end
    reset = 1'b1;
  endtask

  task automatic test_correct_taken();
    drive(1, 1, 32'h40, 32'h08, 0, 0, 0, '0);
    tick();
    drive(0, 0, '0, '0, 1, 1, 1, 32'h40);
    tick();
    idle();
    total++;
    if ({bus.redirectValid, bus.btbUpdate, bus.flushF} !== 3'b000) begin
      bad++; $display("FAIL correct_no_action got=%b exp=000",
                      {bus.redirectValid, bus.btbUpdate, bus.flushF});
    end
    total++;
    if (bus.branchCount !== 16'd1 || bus.mispredictCount !== 16'd0) begin
      bad++; $display("FAIL correct_counts got=%0d/%0d exp=1/0", bus.branchCount, bus.mispredictCount);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL correct_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_cold_miss();
    drive(1, 0, 32'h0, 32'h10, 0, 0, 0, '0);
    tick();
    drive(0, 0, '0, '0, 1, 1, 1, 32'h80);
    tick();
    idle();
    total++;
    if ({bus.redirectValid, bus.redirectPc, bus.btbUpdate, bus.btbPcPlus4, bus.btbTarget, bus.flushF, bus.flushD}
        !== {1'b1, 32'h80, 1'b1, 32'h14, 32'h80, 1'b1, 1'b1}) begin
      bad++; $display("FAIL cold_first_cycle got rv=%b rpc=%h upd=%b p4=%h tgt=%h fl=%b%b exp rv=1 rpc=80 upd=1 p4=14 tgt=80 fl=11",
                      bus.redirectValid, bus.redirectPc, bus.btbUpdate, bus.btbPcPlus4, bus.btbTarget, bus.flushF, bus.flushD);
    end
    tick();
    total++;
    if ({bus.redirectValid, bus.btbUpdate, bus.flushF, bus.flushD} !== 4'b0011) begin
      bad++; $display("FAIL cold_second_cycle got=%b exp=0011",
                      {bus.redirectValid, bus.btbUpdate, bus.flushF, bus.flushD});
    end
    tick();
    total++;
    if ({bus.flushF, bus.flushD} !== 2'b00) begin
      bad++; $display("FAIL cold_flush_end got=%b exp=00", {bus.flushF, bus.flushD});
    end
    drive(0, 0, '0, '0, 1, 1, 1, 32'h80);
    tick();
    idle();
    total++;
    if (bus.redirectValid !== 1'b0 || bus.underflow !== 1'b1) begin
      bad++; $display("FAIL cold_queue_empty got rv=%b uf=%b exp rv=0 uf=1", bus.redirectValid, bus.underflow);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL cold_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_false_taken();
    do_reset();
    drive(1, 1, 32'h40, 32'h20, 0, 0, 0, '0);
    tick();
    drive(0, 0, '0, '0, 1, 0, 0, 32'h40);
    tick();
    idle();
    total++;
    if ({bus.redirectValid, bus.redirectPc, bus.btbUpdate} !== {1'b1, 32'h24, 1'b0}) begin
      bad++; $display("FAIL false_taken_redirect got rv=%b rpc=%h upd=%b exp rv=1 rpc=24 upd=0",
                      bus.redirectValid, bus.redirectPc, bus.btbUpdate);
    end
    total++;
    if (bus.branchCount !== 16'd0 || bus.mispredictCount !== 16'd1) begin
      bad++; $display("FAIL false_taken_counts got=%0d/%0d exp=0/1", bus.branchCount, bus.mispredictCount);
    end
    tick();
    tick();
  endtask

  task automatic test_full_queue();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h1100 + 32'(4*i), 32'h1000 + 32'(4*i), 0, 0, 0, '0);
      tick();
    end
    drive(1, 1, 32'h1110, 32'h1010, 1, 1, 1, 32'h1100);
    tick();
    total++;
    if (bus.overflow !== 1'b0 || bus.redirectValid !== 1'b0) begin
      bad++; $display("FAIL full_push_pop got of=%b rv=%b exp of=0 rv=0", bus.overflow, bus.redirectValid);
    end
    drive(1, 1, 32'h1114, 32'h1014, 0, 0, 0, '0);
    tick();
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++; $display("FAIL full_overflow got=%b exp=1", bus.overflow);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, '0, '0, 1, 1, 1, 32'h1100 + 32'(4*i));
      tick();
      total++;
      if (bus.redirectValid !== 1'b0 || dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_drain_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    drive(0, 0, '0, '0, 1, 1, 1, 32'h1114);
    tick();
    idle();
    total++;
    if (bus.redirectValid !== 1'b0 || bus.underflow !== 1'b1 || bus.branchCount !== 16'd5) begin
      bad++; $display("FAIL full_dropped_gone got rv=%b uf=%b bc=%0d exp rv=0 uf=1 bc=5",
                      bus.redirectValid, bus.underflow, bus.branchCount);
    end
  endtask

  task automatic test_recovery_reset();
    do_reset();
    drive(1, 0, '0, 32'h30, 0, 0, 0, '0);
    tick();
    drive(0, 0, '0, '0, 1, 1, 1, 32'h90);
    tick();
    drive(1, 1, 32'h44, 32'h34, 1, 1, 1, 32'h44);
    tick();
    total++;
    if ({bus.flushF, bus.redirectValid, bus.btbUpdate, bus.overflow, bus.underflow} !== 5'b10000 ||
        bus.branchCount !== 16'd1 || bus.mispredictCount !== 16'd1) begin
      bad++; $display("FAIL recover_ignore got fl=%b rv=%b upd=%b of=%b uf=%b bc=%0d mc=%0d exp fl=1 rv=0 upd=0 of=0 uf=0 bc=1 mc=1",
                      bus.flushF, bus.redirectValid, bus.btbUpdate, bus.overflow, bus.underflow,
                      bus.branchCount, bus.mispredictCount);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if (dut_vec() !== 134'd0) begin
      bad++; $display("FAIL recover_reset got=%h exp=%h", dut_vec(), 134'd0);
    end
    drive(0, 0, '0, '0, 1, 1, 1, 32'h90);
    tick();
    idle();
    total++;
    if (bus.underflow !== 1'b1 || bus.flushF !== 1'b0) begin
      bad++; $display("FAIL recover_underflow got uf=%b fl=%b exp uf=1 fl=0", bus.underflow, bus.flushF);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 0, '0, 32'hFFFF_FFFC, 0, 0, 0, '0);
    tick();
    drive(0, 0, '0, '0, 1, 1, 1, 32'h2000);
    tick();
    idle();
    total++;
    if (bus.btbUpdate !== 1'b1 || bus.btbPcPlus4 !== 32'h0 || bus.btbTarget !== 32'h2000) begin
      bad++; $display("FAIL wrap_pc4 got upd=%b p4=%h tgt=%h exp upd=1 p4=00000000 tgt=00002000",
                      bus.btbUpdate, bus.btbPcPlus4, bus.btbTarget);
    end
    tick();
    tick();
  endtask

  task automatic test_saturate();
    int exp_mc;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      bus_s.pushF = 1; bus_s.hitF = 1; bus_s.btaF = 32'h50; bus_s.pcF = 32'(n * 8);
      bus_s.popE = 0; bus_s.isBranchE = 0; bus_s.branchTakenE = 0; bus_s.aluBranchAddress = '0;
      tick();
      bus_s.pushF = 0; bus_s.popE = 1;
      tick();
      bus_s.popE = 0;
      tick();
      tick();
      exp_mc = (n > 15) ? 15 : n;
      if (n == 10 || n == 20) begin
        total++;
        if (bus_s.mispredictCount !== 4'(exp_mc) || bus_s.branchCount !== 4'd0) begin
          bad++; $display("FAIL saturate_%0d got mc=%0d bc=%0d exp mc=%0d bc=0",
                          n, bus_s.mispredictCount, bus_s.branchCount, exp_mc);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [3];
    addrs[0] = 32'h100; addrs[1] = 32'h200; addrs[2] = 32'h300;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1, addrs[$urandom_range(0, 1)],
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 99) < 45,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addrs[$urandom_range(0, 2)]);
      reset = ($urandom_range(0, 299) != 0);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_cycle_%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle();
    bus_s.pushF = 0; bus_s.hitF = 0; bus_s.btaF = '0; bus_s.pcF = '0;
    bus_s.popE = 0; bus_s.isBranchE = 0; bus_s.branchTakenE = 0; bus_s.aluBranchAddress = '0;
    #2;
    test_reset();
    test_correct_taken();
    test_cold_miss();
    test_false_taken();
    test_full_queue();
    test_recovery_reset();
    test_wrap();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
